// File: rtl/mem_arbiter_if.sv
// Bundle of the CPU, DMA and Memory_Unit signals around the memory arbiter.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface mem_arbiter_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
);
   // CPU MEM-stage port
   logic              cpu_req;
   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic [DATA_W-1:0] cpu_rdata;
   logic              cpu_ack;
   logic              cpu_stall;

   // Boot/DMA loader port
   logic              dma_req;
   logic              dma_we;
   logic              dma_lock;
   logic [ADDR_W-1:0] dma_addr;
   logic [DATA_W-1:0] dma_wdata;
   logic [DATA_W-1:0] dma_rdata;
   logic              dma_ack;

   // Memory_Unit pins
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_din;
   logic [DATA_W-1:0] mem_dout;
   logic              mem_re;
   logic              mem_wr;

   // Owner of the current or most recent access (0=CPU, 1=DMA)
   logic              owner;

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output cpu_rdata, cpu_ack, cpu_stall,
      input  dma_req, dma_we, dma_lock, dma_addr, dma_wdata,
      output dma_rdata, dma_ack,
      output mem_addr, mem_din, mem_re, mem_wr,
      input  mem_dout,
      output owner
   );

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  cpu_rdata, cpu_ack, cpu_stall,
      output dma_req, dma_we, dma_lock, dma_addr, dma_wdata,
      input  dma_rdata, dma_ack,
      input  mem_addr, mem_din, mem_re, mem_wr,
      output mem_dout,
      input  owner
   );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester (CPU / DMA) arbiter and access sequencer for the single-port
// data memory. Round-robin between simultaneous requests, with a DMA lock that
// lets the boot loader keep the memory across consecutive accesses.
module mem_arbiter #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8,
   parameter int RD_LAT = 1
) (
   input logic          clk,
   input logic          rst_n,
   mem_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   // Last read-hold cycle index; rd_cnt runs 0..RD_LAST while re is high.
   localparam logic [2:0] RD_LAST = 3'(RD_LAT - 1);

   state_t            state;
   state_t            state_nxt;
   logic [2:0]        rd_cnt;
   logic              last;
   logic              lock_q;
   logic              we_q;
   logic              owner_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] din_q;
   logic [DATA_W-1:0] cpu_rdata_q;
   logic [DATA_W-1:0] dma_rdata_q;
   logic              grant_any;
   logic              grant_dma;
   logic              cpu_ack;
   logic              dma_ack;
   logic              mem_re;
   logic              mem_wr;

   // Arbitration: a held DMA lock wins outright, otherwise round-robin on last.
   always_comb begin
      grant_any = bus.cpu_req | bus.dma_req;
      if (lock_q && bus.dma_req)
         grant_dma = 1'b1;
      else if (bus.cpu_req && bus.dma_req)
         grant_dma = ~last;
      else
         grant_dma = bus.dma_req;
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Next-state logic: writes take one ACCESS cycle, reads take RD_LAT.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (grant_any) state_nxt = ACCESS;
         ACCESS:  if (we_q || rd_cnt == RD_LAST) state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Output decode from the state register, so reset drops re/wr/ack at once.
   always_comb begin
      mem_re  = (state == ACCESS) && !we_q;
      mem_wr  = (state == ACCESS) &&  we_q;
      cpu_ack = (state == RESP)   && !owner_q;
      dma_ack = (state == RESP)   &&  owner_q;
   end

   // Access registers: latch the winner in IDLE, count/capture reads in
   // ACCESS, and remember whether the finishing DMA access asked for a lock.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q      <= '0;
         din_q       <= '0;
         we_q        <= 1'b0;
         owner_q     <= 1'b1;
         last        <= 1'b1;
         lock_q      <= 1'b0;
         rd_cnt      <= '0;
         cpu_rdata_q <= '0;
         dma_rdata_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               rd_cnt <= '0;
               if (grant_any) begin
                  owner_q <= grant_dma;
                  last    <= grant_dma;
                  if (grant_dma) begin
                     addr_q <= bus.dma_addr;
                     din_q  <= bus.dma_wdata;
                     we_q   <= bus.dma_we;
                  end else begin
                     addr_q <= bus.cpu_addr;
                     din_q  <= bus.cpu_wdata;
                     we_q   <= bus.cpu_we;
                  end
               end
            end
            ACCESS: begin
               if (!we_q) begin
                  if (rd_cnt == RD_LAST) begin
                     rd_cnt <= '0;
                     if (owner_q)
                        dma_rdata_q <= bus.mem_dout;
                     else
                        cpu_rdata_q <= bus.mem_dout;
                  end else begin
                     rd_cnt <= rd_cnt + 3'd1;
                  end
               end
            end
            RESP: begin
               lock_q <= owner_q & bus.dma_lock;
            end
            default: ;
         endcase
      end
   end

   assign bus.mem_addr  = addr_q;
   assign bus.mem_din   = din_q;
   assign bus.mem_re    = mem_re;
   assign bus.mem_wr    = mem_wr;
   assign bus.cpu_ack   = cpu_ack;
   assign bus.dma_ack   = dma_ack;
   assign bus.cpu_rdata = cpu_rdata_q;
   assign bus.dma_rdata = dma_rdata_q;
   assign bus.owner     = owner_q;
   assign bus.cpu_stall = bus.cpu_req & ~cpu_ack;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one DUT with RD_LAT=1 (bus a) and one with
// RD_LAT=3 (bus b), each backed by a small behavioural memory.
module tb_mem_arbiter;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   mem_arbiter_if #(.ADDR_W(8), .DATA_W(8)) a_if ();
   mem_arbiter_if #(.ADDR_W(8), .DATA_W(8)) b_if ();

   mem_arbiter #(.ADDR_W(8), .DATA_W(8), .RD_LAT(1)) u_dut_a (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (a_if)
   );

   mem_arbiter #(.ADDR_W(8), .DATA_W(8), .RD_LAT(3)) u_dut_b (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (b_if)
   );

   logic [7:0] mem_a [256];
   logic [7:0] mem_b [256];

   always @(posedge clk) if (a_if.mem_wr) mem_a[a_if.mem_addr] <= a_if.mem_din;
   always @(posedge clk) if (b_if.mem_wr) mem_b[b_if.mem_addr] <= b_if.mem_din;
   assign a_if.mem_dout = a_if.mem_re ? mem_a[a_if.mem_addr] : 8'h00;
   assign b_if.mem_dout = b_if.mem_re ? mem_b[b_if.mem_addr] : 8'h00;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: sim time limit reached, required $finish earlier");
      $fatal(1, "watchdog");
   end

   // Issue a CPU read on bus a and wait (bounded) for its ack; no checking.
   task automatic cpu_read_a(input logic [7:0] addr, output logic [7:0] data,
                             output int ack_cyc, output int re_cnt);
      @(negedge clk);
      a_if.cpu_req = 1'b1; a_if.cpu_we = 1'b0; a_if.cpu_addr = addr;
      ack_cyc = 0; re_cnt = 0; data = 8'h00;
      for (int c = 2; c <= 12 && ack_cyc == 0; c++) begin
         @(negedge clk);
         if (a_if.mem_re) re_cnt++;
         if (a_if.cpu_ack) begin
            ack_cyc = c;
            data = a_if.cpu_rdata;
         end
      end
      a_if.cpu_req = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      a_if.cpu_req = 0; a_if.cpu_we = 0; a_if.cpu_addr = 0; a_if.cpu_wdata = 0;
      a_if.dma_req = 0; a_if.dma_we = 0; a_if.dma_lock = 0; a_if.dma_addr = 0; a_if.dma_wdata = 0;
      b_if.cpu_req = 0; b_if.cpu_we = 0; b_if.cpu_addr = 0; b_if.cpu_wdata = 0;
      b_if.dma_req = 0; b_if.dma_we = 0; b_if.dma_lock = 0; b_if.dma_addr = 0; b_if.dma_wdata = 0;
      repeat (2) @(negedge clk);
      checks++;
      if ({a_if.mem_re, a_if.mem_wr, a_if.cpu_ack, a_if.dma_ack, a_if.owner} !== 5'b00001) begin
         errors++;
         $display("FAIL reset_ctrl: re,wr,cack,dack,owner=%b required 00001",
                  {a_if.mem_re, a_if.mem_wr, a_if.cpu_ack, a_if.dma_ack, a_if.owner});
      end
      checks++;
      if ({a_if.mem_addr, a_if.mem_din, a_if.cpu_rdata, a_if.dma_rdata} !== 32'h0) begin
         errors++;
         $display("FAIL reset_data: addr,din,crd,drd=%h required 00000000",
                  {a_if.mem_addr, a_if.mem_din, a_if.cpu_rdata, a_if.dma_rdata});
      end
      checks++;
      if (b_if.owner !== 1'b1) begin
         errors++;
         $display("FAIL reset_owner_b: got %b required 1", b_if.owner);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_cpu_write();
      @(negedge clk);
      a_if.cpu_req = 1'b1; a_if.cpu_we = 1'b1; a_if.cpu_addr = 8'h10; a_if.cpu_wdata = 8'hA5;
      #1;
      checks++;
      if (a_if.cpu_stall !== 1'b1 || a_if.mem_wr !== 1'b0) begin
         errors++;
         $display("FAIL wr_cycle1: stall=%b wr=%b required stall=1 wr=0", a_if.cpu_stall, a_if.mem_wr);
      end
      @(negedge clk);
      checks++;
      if ({a_if.mem_wr, a_if.mem_re, a_if.mem_addr, a_if.mem_din, a_if.cpu_stall, a_if.cpu_ack} !== {2'b10, 8'h10, 8'hA5, 2'b10}) begin
         errors++;
         $display("FAIL wr_cycle2: wr=%b re=%b addr=%h din=%h stall=%b ack=%b required 1 0 10 a5 1 0",
                  a_if.mem_wr, a_if.mem_re, a_if.mem_addr, a_if.mem_din, a_if.cpu_stall, a_if.cpu_ack);
      end
      @(negedge clk);
      checks++;
      if ({a_if.cpu_ack, a_if.cpu_stall, a_if.dma_ack, a_if.owner, a_if.mem_wr} !== 5'b10000) begin
         errors++;
         $display("FAIL wr_cycle3: ack=%b stall=%b dack=%b owner=%b wr=%b required 1 0 0 0 0",
                  a_if.cpu_ack, a_if.cpu_stall, a_if.dma_ack, a_if.owner, a_if.mem_wr);
      end
      a_if.cpu_req = 1'b0; a_if.cpu_we = 1'b0;
      @(negedge clk);
      checks++;
      if (mem_a[8'h10] !== 8'hA5) begin
         errors++;
         $display("FAIL wr_mem: mem[10]=%h required a5", mem_a[8'h10]);
      end
   endtask

   task automatic test_cpu_read_lat1();
      logic [7:0] d;
      int ack_cyc, re_cnt;
      cpu_read_a(8'h10, d, ack_cyc, re_cnt);
      checks++;
      if (re_cnt != 1 || ack_cyc != 3 || d !== 8'hA5) begin
         errors++;
         $display("FAIL rd_lat1: re_cycles=%0d ack_cycle=%0d rdata=%h required 1 3 a5", re_cnt, ack_cyc, d);
      end
   endtask

   task automatic test_cpu_read_lat3();
      int ack_cyc, re_cnt;
      logic [7:0] d;
      // load A5 at 10 through the RD_LAT=3 arbiter
      @(negedge clk);
      b_if.cpu_req = 1'b1; b_if.cpu_we = 1'b1; b_if.cpu_addr = 8'h10; b_if.cpu_wdata = 8'hA5;
      ack_cyc = 0;
      for (int c = 2; c <= 12 && ack_cyc == 0; c++) begin
         @(negedge clk);
         if (b_if.cpu_ack) ack_cyc = c;
      end
      b_if.cpu_req = 1'b0;
      checks++;
      if (ack_cyc != 3) begin
         errors++;
         $display("FAIL wr_lat3: ack_cycle=%0d required 3", ack_cyc);
      end
      @(negedge clk);
      b_if.cpu_req = 1'b1; b_if.cpu_we = 1'b0; b_if.cpu_addr = 8'h10;
      ack_cyc = 0; re_cnt = 0; d = 8'h00;
      for (int c = 2; c <= 12 && ack_cyc == 0; c++) begin
         @(negedge clk);
         if (b_if.mem_re) re_cnt++;
         if (b_if.cpu_ack) begin
            ack_cyc = c;
            d = b_if.cpu_rdata;
         end
      end
      b_if.cpu_req = 1'b0;
      checks++;
      if (re_cnt != 3 || ack_cyc != 5 || d !== 8'hA5) begin
         errors++;
         $display("FAIL rd_lat3: re_cycles=%0d ack_cycle=%0d rdata=%h required 3 5 a5", re_cnt, ack_cyc, d);
      end
   endtask

   task automatic test_round_robin();
      logic [3:0] seq;
      int n;
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      a_if.cpu_req = 1'b1; a_if.cpu_we = 1'b1; a_if.cpu_addr = 8'h20; a_if.cpu_wdata = 8'h11;
      a_if.dma_req = 1'b1; a_if.dma_we = 1'b1; a_if.dma_addr = 8'h30; a_if.dma_wdata = 8'h22;
      a_if.dma_lock = 1'b0;
      seq = 4'b0; n = 0;
      for (int c = 0; c < 20 && n < 4; c++) begin
         @(negedge clk);
         checks++;
         if (a_if.cpu_ack && a_if.dma_ack) begin
            errors++;
            $display("FAIL rr_dual_ack: cack=1 dack=1 required at most one");
         end
         if (a_if.cpu_ack || a_if.dma_ack) begin
            seq = {seq[2:0], a_if.dma_ack};
            n++;
            checks++;
            if (a_if.owner !== a_if.dma_ack) begin
               errors++;
               $display("FAIL rr_owner: owner=%b required %b", a_if.owner, a_if.dma_ack);
            end
         end
      end
      a_if.cpu_req = 1'b0; a_if.dma_req = 1'b0;
      checks++;
      if (n != 4 || seq !== 4'b0101) begin
         errors++;
         $display("FAIL rr_order: grants=%0d order=%b required 4 0101 (CPU,DMA,CPU,DMA)", n, seq);
      end
      checks++;
      if (mem_a[8'h20] !== 8'h11 || mem_a[8'h30] !== 8'h22 || a_if.cpu_rdata !== 8'h00) begin
         errors++;
         $display("FAIL rr_data: mem20=%h mem30=%h crd=%h required 11 22 00",
                  mem_a[8'h20], mem_a[8'h30], a_if.cpu_rdata);
      end
   endtask

   task automatic test_dma_lock_burst();
      int dma_n, cpu_at;
      @(negedge clk);
      a_if.dma_req = 1'b1; a_if.dma_we = 1'b1; a_if.dma_lock = 1'b1;
      a_if.dma_addr = 8'h00; a_if.dma_wdata = 8'h00;
      @(negedge clk);
      a_if.cpu_req = 1'b1; a_if.cpu_we = 1'b1; a_if.cpu_addr = 8'h40; a_if.cpu_wdata = 8'h5A;
      dma_n = 0; cpu_at = -1;
      for (int c = 0; c < 40 && cpu_at < 0; c++) begin
         @(negedge clk);
         if (a_if.cpu_ack) begin
            cpu_at = dma_n;
         end else begin
            checks++;
            if (a_if.cpu_stall !== 1'b1) begin
               errors++;
               $display("FAIL lock_stall: stall=%b after %0d dma acks required 1", a_if.cpu_stall, dma_n);
            end
         end
         if (a_if.dma_ack) begin
            dma_n++;
            if (dma_n < 4) begin
               a_if.dma_addr = 8'(dma_n); a_if.dma_wdata = 8'(dma_n);
            end else begin
               a_if.dma_lock = 1'b0;
            end
         end
      end
      a_if.cpu_req = 1'b0; a_if.dma_req = 1'b0;
      checks++;
      if (cpu_at != 4) begin
         errors++;
         $display("FAIL lock_order: cpu granted after %0d dma accesses required 4", cpu_at);
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (mem_a[i] !== 8'(i)) begin
            errors++;
            $display("FAIL lock_mem%0d: got %h required %h", i, mem_a[i], 8'(i));
         end
      end
      checks++;
      if (mem_a[8'h40] !== 8'h5A) begin
         errors++;
         $display("FAIL lock_cpu_wr: mem40=%h required 5a", mem_a[8'h40]);
      end
   endtask

   task automatic test_reset_mid_read();
      logic [7:0] d;
      int ack_cyc, re_cnt;
      cpu_read_a(8'h10, d, ack_cyc, re_cnt);
      checks++;
      if (d !== 8'hA5 || ack_cyc != 3) begin
         errors++;
         $display("FAIL pre_abort_rd: rdata=%h ack_cycle=%0d required a5 3", d, ack_cyc);
      end
      @(negedge clk);
      a_if.cpu_req = 1'b1; a_if.cpu_we = 1'b0; a_if.cpu_addr = 8'h40;
      @(negedge clk);
      checks++;
      if (a_if.mem_re !== 1'b1) begin
         errors++;
         $display("FAIL abort_access: re=%b required 1", a_if.mem_re);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({a_if.mem_re, a_if.cpu_ack, a_if.dma_ack, a_if.owner, a_if.cpu_rdata} !== {4'b0001, 8'h00}) begin
         errors++;
         $display("FAIL abort_reset: re=%b cack=%b dack=%b owner=%b crd=%h required 0 0 0 1 00",
                  a_if.mem_re, a_if.cpu_ack, a_if.dma_ack, a_if.owner, a_if.cpu_rdata);
      end
      a_if.cpu_req = 1'b0;
      @(negedge clk);
      checks++;
      if (a_if.cpu_ack !== 1'b0 || a_if.mem_re !== 1'b0) begin
         errors++;
         $display("FAIL abort_hold: ack=%b re=%b required 0 0", a_if.cpu_ack, a_if.mem_re);
      end
      rst_n = 1'b1;
      cpu_read_a(8'h40, d, ack_cyc, re_cnt);
      checks++;
      if (d !== 8'h5A || ack_cyc != 3 || re_cnt != 1) begin
         errors++;
         $display("FAIL post_abort_rd: rdata=%h ack_cycle=%0d re_cycles=%0d required 5a 3 1", d, ack_cyc, re_cnt);
      end
   endtask

   task automatic test_idle();
      int ack_cyc;
      @(negedge clk);
      a_if.dma_req = 1'b1; a_if.dma_we = 1'b0; a_if.dma_lock = 1'b0; a_if.dma_addr = 8'h03;
      ack_cyc = 0;
      for (int c = 2; c <= 12 && ack_cyc == 0; c++) begin
         @(negedge clk);
         if (a_if.dma_ack) ack_cyc = c;
      end
      a_if.dma_req = 1'b0;
      checks++;
      if (ack_cyc != 3 || a_if.dma_rdata !== 8'h03 || a_if.cpu_rdata !== 8'h5A || a_if.owner !== 1'b1) begin
         errors++;
         $display("FAIL dma_read: ack_cycle=%0d drd=%h crd=%h owner=%b required 3 03 5a 1",
                  ack_cyc, a_if.dma_rdata, a_if.cpu_rdata, a_if.owner);
      end
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         checks++;
         if ({a_if.mem_re, a_if.mem_wr, a_if.cpu_ack, a_if.dma_ack, a_if.cpu_rdata, a_if.dma_rdata} !== {4'b0000, 8'h5A, 8'h03}) begin
            errors++;
            $display("FAIL idle_%0d: re=%b wr=%b cack=%b dack=%b crd=%h drd=%h required 0 0 0 0 5a 03", c,
                     a_if.mem_re, a_if.mem_wr, a_if.cpu_ack, a_if.dma_ack, a_if.cpu_rdata, a_if.dma_rdata);
         end
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_cpu_write();
      test_cpu_read_lat1();
      test_cpu_read_lat3();
      test_round_robin();
      test_dma_lock_burst();
      test_reset_mid_read();
      test_idle();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
